// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon permutation core.
//   state_t    : five 64-bit words x0..x4; x0 sits in the MSBs when packed.
//   ROT0..ROT4 : rotation pairs of the linear layer, one pair per word.
//   MAX_ROUNDS : upper clamp for a requested round count.
//   fsm_e      : sequencer states of ascon_permutation.
package ascon_pkg;

    localparam int unsigned MAX_ROUNDS = 12;

    // Element 0 is the leftmost (most significant) word, so the packed
    // form is exactly {x0,x1,x2,x3,x4}.
    typedef logic [0:4][63:0] state_t;

    typedef logic [0:1][5:0] rot_pair_t;

    localparam rot_pair_t ROT0 = {6'd19, 6'd28};
    localparam rot_pair_t ROT1 = {6'd61, 6'd39};
    localparam rot_pair_t ROT2 = {6'd1,  6'd6};
    localparam rot_pair_t ROT3 = {6'd10, 6'd17};
    localparam rot_pair_t ROT4 = {6'd7,  6'd41};

    localparam logic [0:4][0:1][5:0] ROT = {ROT0, ROT1, ROT2, ROT3, ROT4};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    function automatic logic [319:0] pack_state(input state_t s);
        return s;
    endfunction

    function automatic state_t unpack_state(input logic [319:0] v);
        return state_t'(v);
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input logic [5:0] n);
        return (x >> n) | (x << (7'd64 - {1'b0, n}));
    endfunction

endpackage

// File: rtl/ascon_const_add.sv
// Constant-addition stage: XORs the round constant selected by rnd_i into
// the low byte of x2.
//   rnd_i    : 4-bit round index (0..15, 16-round schedule)
//   x2_lo_i  : low byte of x2 before the constant
//   x2_lo_o  : low byte of x2 after the constant
module ascon_const_add (
    input  logic [3:0] rnd_i,
    input  logic [7:0] x2_lo_i,
    output logic [7:0] x2_lo_o
);

    logic [7:0] rc;

    always_comb begin
        rc = 8'h00;
        case (rnd_i)
            4'd0:  rc = 8'h3c;
            4'd1:  rc = 8'h2d;
            4'd2:  rc = 8'h1e;
            4'd3:  rc = 8'h0f;
            4'd4:  rc = 8'hf0;
            4'd5:  rc = 8'he1;
            4'd6:  rc = 8'hd2;
            4'd7:  rc = 8'hc3;
            4'd8:  rc = 8'hb4;
            4'd9:  rc = 8'ha5;
            4'd10: rc = 8'h96;
            4'd11: rc = 8'h87;
            4'd12: rc = 8'h78;
            4'd13: rc = 8'h69;
            4'd14: rc = 8'h5a;
            4'd15: rc = 8'h4b;
            default: rc = 8'h00;
        endcase
        x2_lo_o = x2_lo_i ^ rc;
    end

endmodule

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, S-box layer, linear layer.
//   state_i : state before the round
//   rnd_i   : round index selecting the constant
//   state_o : state after the round
module ascon_round
    import ascon_pkg::*;
(
    input  state_t     state_i,
    input  logic [3:0] rnd_i,
    output state_t     state_o
);

    logic [7:0]  x2_lo_c;
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] t0, t1, t2, t3, t4;
    state_t      s_sbox;

    ascon_const_add u_const_add (
        .rnd_i   (rnd_i),
        .x2_lo_i (state_i[2][7:0]),
        .x2_lo_o (x2_lo_c)
    );

    // Bit-sliced 5-bit S-box: every bit position of the five words is one
    // S-box column, x0 being the index MSB.
    always_comb begin
        a0 = state_i[0];
        a1 = state_i[1];
        a2 = {state_i[2][63:8], x2_lo_c};
        a3 = state_i[3];
        a4 = state_i[4];

        a0 = a0 ^ a4;
        a4 = a4 ^ a3;
        a2 = a2 ^ a1;

        t0 = ~a0 & a1;
        t1 = ~a1 & a2;
        t2 = ~a2 & a3;
        t3 = ~a3 & a4;
        t4 = ~a4 & a0;

        a0 = a0 ^ t1;
        a1 = a1 ^ t2;
        a2 = a2 ^ t3;
        a3 = a3 ^ t4;
        a4 = a4 ^ t0;

        a1 = a1 ^ a0;
        a0 = a0 ^ a4;
        a3 = a3 ^ a2;
        a2 = ~a2;

        s_sbox = {a0, a1, a2, a3, a4};
    end

    always_comb begin
        state_o = '0;
        for (int i = 0; i < 5; i++) begin
            state_o[i] = s_sbox[i] ^ ror64(s_sbox[i], ROT[i][0])
                                   ^ ror64(s_sbox[i], ROT[i][1]);
        end
    end

endmodule

// File: rtl/ascon_permutation.sv
// Iterative Ascon permutation p^N, one round per clock on a registered
// 320-bit state.
//   clk, rst_n  : clock, synchronous active-low reset
//   start_i     : request; accepted only while ready_o=1
//   nrounds_i   : round count, clamped to MAX_ROUNDS, sampled with start_i
//   state_i     : input state {x0..x4}
//   state_o     : register contents; result valid while done_o=1 and held
//                 until the next accept
//   ready_o     : IDLE or DONE
//   busy_o      : RUN
//   done_o      : one cycle in DONE after each permutation
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_i
// RUN   | applying round rnd_q each edge; rnd_q==15 is the last round
// DONE  | result on state_o; start_i here launches the next permutation
module ascon_permutation
    import ascon_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [3:0]   nrounds_i,
    input  logic [319:0] state_i,
    output logic [319:0] state_o,
    output logic         ready_o,
    output logic         busy_o,
    output logic         done_o
);

    fsm_e       fsm_q, fsm_d;
    logic [3:0] rnd_q, rnd_d;
    state_t     state_q, state_d;
    state_t     round_out;
    logic [3:0] n_clamped;

    ascon_round u_round (
        .state_i (state_q),
        .rnd_i   (rnd_q),
        .state_o (round_out)
    );

    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_q;

        n_clamped = (nrounds_i > 4'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : nrounds_i;

        case (fsm_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = unpack_state(state_i);
                    // 16-N modulo 16, so the last round always lands on rnd 15.
                    rnd_d   = 4'd0 - n_clamped;
                    fsm_d   = (n_clamped == 4'd0) ? DONE : RUN;
                end else begin
                    fsm_d = IDLE;
                end
            end
            RUN: begin
                state_d = round_out;
                rnd_d   = rnd_q + 4'd1;
                if (rnd_q == 4'd15) begin
                    fsm_d = DONE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            rnd_q   <= 4'd0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
        end
    end

    assign state_o = pack_state(state_q);
    assign ready_o = (fsm_q == IDLE) || (fsm_q == DONE);
    assign busy_o  = (fsm_q == RUN);
    assign done_o  = (fsm_q == DONE);

endmodule

// File: doc/ascon_permutation.md
Name: ascon_permutation

Overview:
Iterative Ascon permutation core, p^a/p^b, computing one round per clock on a registered 320-bit state. It sits directly upstream of the constant-addition stage. It owns the round counter that drives that stage's 4-bit `rnd` select, and it feeds the stage the low byte of x2. The constant-addition, substitution and linear layers are applied combinationally each cycle. Start/done handshake toward the mode controller (init/AD/finalization sequencer).

Parameters:
- MAX_ROUNDS, 12, upper clamp for the requested round count. Fixed by the Ascon spec; not to be overridden.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start_i  in  1  request a permutation; sampled only when ready_o=1
- nrounds_i  in  4  rounds to run (Ascon uses 12, 8 or 6); sampled with start_i
- state_i  in  320  input state, {x0,x1,x2,x3,x4}, x0 in [319:256], x4 in [63:0]
- state_o  out  320  permutation result, same word order
- ready_o  out  1  1 in IDLE and DONE
- busy_o  out  1  1 in RUN
- done_o  out  1  one-cycle pulse when state_o holds a fresh result

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low, rst_n, sampled on the rising edge of clk.
- Values while rst_n=0 (after the edge): FSM=IDLE, state reg=0, rnd_q=0, state_o=0, ready_o=1, busy_o=0, done_o=0.
- Reset mid-RUN: abort, state cleared, no done_o pulse.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE --(start_i)--> RUN
  - RUN --(rnd_q==15 applied)--> DONE
  - DONE --(start_i)--> RUN (back-to-back accepted)
  - DONE --(no start_i)--> IDLE
- Accept edge (start_i & ready_o):
  - Let N = nrounds_i, clamped to MAX_ROUNDS if larger.
  - state reg <= state_i.
  - rnd_q <= 16-N (4 for 12 rounds, 8 for 8, 10 for 6).
- N=0 special case: go directly to DONE with state_i unchanged, so done_o fires on the next cycle.
- RUN, each edge:
  - state reg <= round(state reg, rnd_q).
  - rnd_q <= rnd_q+1.
  - The edge on which rnd_q==15 applies the last round and moves to DONE.
  - rnd_q wraps 15->0 on that edge; the wrapped value is never used.
- start_i during RUN is ignored: no queuing, no error.
- Latency: accept edge E0, rounds applied on edges E1..EN, done_o high during the cycle after EN (N+1 cycles from accept to done_o). Throughput is one permutation per N+1 cycles when back-to-back.
- state_o is driven directly from the state reg.
  - It is valid when done_o=1 and held stable until the next accept edge.
  - During RUN it shows intermediate round states, which downstream must not use.
- Round function, combinational, in order:
  - pc: x2[7:0] ^= const(rnd_q), using the constant-addition stage's table. The round for index r uses the constant at rnd=r, e.g. 0xF0 at rnd 4 and 0x4B at rnd 15.
  - ps: 5-bit Ascon S-box applied bit-sliced to each of the 64 columns; bit x0 is the MSB of the S-box index.
  - pl: xi ^= ror(xi,a) ^ ror(xi,b), with rotation pairs x0:(19,28), x1:(61,39), x2:(1,6), x3:(10,17), x4:(7,41).
- All arithmetic is bitwise on 64-bit words; there is no carry logic.

Decomposition:
- ascon_pkg holds:
  - state_t (array of five 64-bit words) and pack/unpack of the 320-bit vector.
  - Rotation constants ROT0..ROT4 (pairs).
  - MAX_ROUNDS.
  - FSM enum {IDLE,RUN,DONE}.
- Sub-module ascon_round: purely combinational, state_t in, rnd in, state_t out. It instantiates the existing constant-addition stage for x2[7:0] and implements the S-box and linear layers.
- ascon_permutation holds only the FSM, rnd_q and the state register.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles mid-RUN -> state_o=0, ready_o=1, busy_o=0, done_o never pulses; the next start runs normally.
- 12 rounds, state_i = Ascon-128 initial IV/key/nonce state (IV 0x80400c0600000000, key and nonce 0) -> done_o exactly 13 cycles after accept; state_o matches the C reference p^12; busy_o high for 12 cycles.
- 1 round, state_i=0:
  - rnd 15 is used, so x2 low byte = 0x4B before ps.
  - Required: state_o x4 word = 0x0000000000000000; all five words match the golden model.
- 6 and 8 rounds on a random state -> rnd_q sequences 10..15 and 8..15 respectively; done_o at 7 and 9 cycles after accept; results match the golden model.
- Back-to-back and ignored starts:
  - start_i held high continuously -> a new accept occurs in every DONE cycle; done_o pulses every N+1 cycles.
  - A start_i pulse during RUN -> no effect on result or timing.
- Boundaries:
  - nrounds_i=15 -> clamped to 12 (same result and timing as 12).
  - nrounds_i=0 -> done_o one cycle after accept with state_o == state_i.
